// File: rtl/mem_mfc_if.sv
// Request/completion bus between the control unit (master) and the memory (slave).
// The CU holds mfa high until it sees mfc, then drops it for at least one cycle.
interface mem_mfc_if;
    logic        mfa;
    logic        rw;
    logic [1:0]  size;
    logic        signed_rd;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mfc;
    logic        align_err;
    logic        busy;

    modport master (
        output mfa, rw, size, signed_rd, addr, din,
        input  dout, mfc, align_err, busy
    );

    modport slave (
        input  mfa, rw, size, signed_rd, addr, din,
        output dout, mfc, align_err, busy
    );
endinterface

// File: rtl/mem_mfc_ctrl.sv
// Byte-addressed big-endian memory with an MFA/MFC handshake and a fixed wait time.
// Byte, halfword and word accesses; misaligned accesses complete with align_err.
module mem_mfc_ctrl #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      reset,
    mem_mfc_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [7:0] mem [0:DEPTH-1];

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                rw_reg;
    logic [1:0]          size_reg;
    logic                signed_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         din_reg;
    logic [31:0]         dout_reg, dout_next;

    logic                accept;
    logic                exec;
    logic                misaligned;
    logic                rd_commit;
    logic                wr_commit;
    logic [31:0]         wdata_aligned;
    logic [3:0]          we_mask;
    logic [ADDR_W-1:0]   lane_addr [4];
    logic [7:0]          lane_wd   [4];
    logic [7:0]          rd_byte   [4];
    logic                unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[31:ADDR_W];

    assign accept     = (state_reg == S_IDLE) && bus.mfa;
    assign exec       = (state_reg == S_WAIT) && (cnt_reg == 4'd0);
    assign misaligned = (size_reg[1] && (addr_reg[1:0] != 2'b00)) ||
                        ((size_reg == 2'b01) && addr_reg[0]);
    assign rd_commit  = exec && rw_reg && !misaligned;
    assign wr_commit  = exec && !rw_reg && !misaligned;

    // Left-justify write data so lane 0 (lowest address) always takes bits 31:24.
    always_comb begin
        wdata_aligned = {din_reg[7:0], 24'h0};
        we_mask       = 4'b1000;
        if (size_reg[1]) begin
            wdata_aligned = din_reg;
            we_mask       = 4'b1111;
        end else if (size_reg[0]) begin
            wdata_aligned = {din_reg[15:0], 16'h0};
            we_mask       = 4'b1100;
        end
    end

    // Each lane address wraps on its own, so a word never spills past DEPTH.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi] = addr_reg + ADDR_W'(gi);
            assign lane_wd[gi]   = wdata_aligned[31-8*gi -: 8];
            assign rd_byte[gi]   = mem[lane_addr[gi]];
        end
    endgenerate

    always_comb begin
        if (size_reg[1]) begin
            dout_next = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        end else if (size_reg[0]) begin
            dout_next = {{16{signed_reg & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
        end else begin
            dout_next = {{24{signed_reg & rd_byte[0][7]}}, rd_byte[0]};
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.mfa) begin
                    state_next = S_WAIT;
                    cnt_next   = 4'(WAIT_CYCLES - 1);
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_DONE: begin
                if (!bus.mfa) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 4'd0;
            rw_reg     <= 1'b0;
            size_reg   <= 2'b00;
            signed_reg <= 1'b0;
            addr_reg   <= '0;
            din_reg    <= 32'h0;
            dout_reg   <= 32'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                rw_reg     <= bus.rw;
                size_reg   <= bus.size;
                signed_reg <= bus.signed_rd;
                addr_reg   <= bus.addr[ADDR_W-1:0];
                din_reg    <= bus.din;
            end
            if (rd_commit) begin
                dout_reg <= dout_next;
            end
        end
    end

    // Reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_commit && !reset && we_mask[3-i]) begin
                mem[lane_addr[i]] <= lane_wd[i];
            end
        end
    end

    assign bus.dout      = dout_reg;
    assign bus.mfc       = (state_reg == S_DONE);
    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.align_err = (state_reg == S_DONE) && misaligned;
endmodule

// File: tb/tb_mem_mfc_ctrl.sv
// Directed bench for mem_mfc_ctrl: handshake timing, endianness, extension,
// alignment errors, address wrap and reset abort.
module tb_mem_mfc_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_mfc_if bus();

    mem_mfc_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full handshake; request fields are scrambled right after acceptance.
    task automatic access(input string tag, input logic rw, input logic [1:0] size,
                          input logic sg, input logic [31:0] addr, input logic [31:0] din,
                          input logic [31:0] exp_dout, input logic exp_err);
        int lat;
        bus.mfa       = 1'b1;
        bus.rw        = rw;
        bus.size      = size;
        bus.signed_rd = sg;
        bus.addr      = addr;
        bus.din       = din;
        @(posedge clk); #1;
        bus.rw        = ~rw;
        bus.size      = ~size;
        bus.signed_rd = ~sg;
        bus.addr      = ~addr;
        bus.din       = ~din;
        check({tag, "_busy"}, {31'h0, bus.busy}, 32'h1);
        lat = 0;
        while (bus.mfc !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_dout"}, bus.dout, exp_dout);
        check({tag, "_aerr"}, {31'h0, bus.align_err}, {31'h0, exp_err});
        @(posedge clk); #1;
        check({tag, "_mfc_hold"}, {31'h0, bus.mfc}, 32'h1);
        bus.mfa = 1'b0;
        @(posedge clk); #1;
        check({tag, "_mfc_drop"}, {31'h0, bus.mfc}, 32'h0);
        check({tag, "_aerr_clr"}, {31'h0, bus.align_err}, 32'h0);
        check({tag, "_idle"}, {31'h0, bus.busy}, 32'h0);
        $display("txn %s rw=%0b size=%0d addr=%h din=%h dout=%h aerr=%0b lat=%0d",
                 tag, rw, size, addr, din, bus.dout, exp_err, lat);
    endtask

    initial begin
        int lat;
        total = 0;
        bad   = 0;

        // Reset held with a pending word read at 4.
        reset         = 1'b1;
        bus.mfa       = 1'b1;
        bus.rw        = 1'b1;
        bus.size      = 2'b10;
        bus.signed_rd = 1'b0;
        bus.addr      = 32'h4;
        bus.din       = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_mfc", {31'h0, bus.mfc}, 32'h0);
            check("rst_busy", {31'h0, bus.busy}, 32'h0);
            check("rst_dout", bus.dout, 32'h0);
            check("rst_aerr", {31'h0, bus.align_err}, 32'h0);
            if (i == 0) begin
                dut.mem[4]  = 8'h9C; dut.mem[5]  = 8'h04;
                dut.mem[6]  = 8'h40; dut.mem[7]  = 8'h12;
                dut.mem[8]  = 8'h11; dut.mem[9]  = 8'h22;
                dut.mem[10] = 8'h33; dut.mem[11] = 8'h44;
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("first_accept", {31'h0, bus.busy}, 32'h1);
        lat = 0;
        while (bus.mfc !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rd_w4_lat", 32'(lat), 32'd2);
        check("rd_w4_dout", bus.dout, 32'h9C044012);
        @(posedge clk); #1;
        check("rd_w4_mfc_hold", {31'h0, bus.mfc}, 32'h1);
        bus.mfa = 1'b0;
        @(posedge clk); #1;
        check("rd_w4_mfc_drop", {31'h0, bus.mfc}, 32'h0);
        $display("txn rd_w4 dout=%h lat=%0d", bus.dout, lat);

        access("rd_b_s",    1'b1, 2'b00, 1'b1, 32'h4,        32'h0,        32'hFFFFFF9C, 1'b0);
        access("rd_b_u",    1'b1, 2'b00, 1'b0, 32'h4,        32'h0,        32'h0000009C, 1'b0);
        access("rd_h_s",    1'b1, 2'b01, 1'b1, 32'h4,        32'h0,        32'hFFFF9C04, 1'b0);
        access("wr_h10",    1'b0, 2'b01, 1'b0, 32'hA,        32'h0000ABCD, 32'hFFFF9C04, 1'b0);
        access("rd_w8",     1'b1, 2'b10, 1'b0, 32'h8,        32'h0,        32'h1122ABCD, 1'b0);
        access("wr_w6_mis", 1'b0, 2'b10, 1'b0, 32'h6,        32'h01020304, 32'h1122ABCD, 1'b1);
        access("rd_w4_s11", 1'b1, 2'b11, 1'b0, 32'h4,        32'h0,        32'h9C044012, 1'b0);
        access("rd_h5_mis", 1'b1, 2'b01, 1'b1, 32'h5,        32'h0,        32'h9C044012, 1'b1);
        access("rd_b5",     1'b1, 2'b00, 1'b1, 32'h5,        32'h0,        32'h00000004, 1'b0);
        access("wr_w100",   1'b0, 2'b10, 1'b0, 32'h100,      32'hDEADBEEF, 32'h00000004, 1'b0);
        access("rd_w0",     1'b1, 2'b10, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0);
        access("rd_wrap",   1'b1, 2'b10, 1'b0, 32'hFFFFFF00, 32'h0,        32'hDEADBEEF, 1'b0);

        // Reset lands on the edge that would commit a write to 0.
        bus.mfa  = 1'b1;
        bus.rw   = 1'b0;
        bus.size = 2'b10;
        bus.addr = 32'h0;
        bus.din  = 32'h11223344;
        @(posedge clk); #1;
        check("abort_busy", {31'h0, bus.busy}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_mfc", {31'h0, bus.mfc}, 32'h0);
        check("abort_busy0", {31'h0, bus.busy}, 32'h0);
        check("abort_dout", bus.dout, 32'h0);
        $display("txn abort_wr0 busy=%0b mfc=%0b", bus.busy, bus.mfc);
        reset   = 1'b0;
        bus.mfa = 1'b0;
        @(posedge clk); #1;
        access("rd_w0_after", 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
